// File: rtl/memshare_grant_sched_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | memshare_pkg                                                               |
// | Shared types and helpers for the memory-share grant scheduler.             |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
package memshare_pkg;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SERVE = 1'b1
  } state_e;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

  function automatic int port_sel_width(input int port_num);
    return (clog2(port_num) < 1) ? 1 : clog2(port_num);
  endfunction

endpackage
`default_nettype wire

// File: rtl/memshare_grant_sched_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | memshare_grant_sched_if                                                    |
// | Batch request / grant bundle between requestor side and scheduler.         |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
interface memshare_grant_sched_if #(
  parameter int SHARED_BANK_NUM = 5,
  parameter int PORT_NUM        = 2,
  parameter int ROUND_BITWIDTH  = 3
);
  localparam int PORT_SEL_BITWIDTH = memshare_pkg::port_sel_width(PORT_NUM);

  logic                                         rqst_valid_i;
  logic [SHARED_BANK_NUM-1:0]                   share_rqstFlag_i;
  logic                                         flush_i;
  logic                                         rqst_ready_o;
  logic                                         grant_valid_o;
  logic [SHARED_BANK_NUM-1:0]                   grant_o;
  logic [SHARED_BANK_NUM*PORT_SEL_BITWIDTH-1:0] port_sel_o;
  logic [ROUND_BITWIDTH-1:0]                    round_o;
  logic                                         endFlag_o;

  modport master (
    output rqst_valid_i, share_rqstFlag_i, flush_i,
    input  rqst_ready_o, grant_valid_o, grant_o, port_sel_o, round_o, endFlag_o
  );

  modport slave (
    input  rqst_valid_i, share_rqstFlag_i, flush_i,
    output rqst_ready_o, grant_valid_o, grant_o, port_sel_o, round_o, endFlag_o
  );
endinterface
`default_nettype wire

// File: rtl/memshare_grant_sched_lowk_select.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | memshare_lowk_select                                                       |
// | Picks the lowest PORT_NUM set bits and ranks each pick as its port index.  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module memshare_lowk_select #(
  parameter int SHARED_BANK_NUM   = 5,
  parameter int PORT_NUM          = 2,
  parameter int PORT_SEL_BITWIDTH = 1
) (
  input  logic [SHARED_BANK_NUM-1:0]                   pending_i,
  output logic [SHARED_BANK_NUM-1:0]                   sel_o,
  output logic [SHARED_BANK_NUM*PORT_SEL_BITWIDTH-1:0] port_sel_o
);

  always_comb begin
    int unsigned cnt;
    cnt        = 0;
    sel_o      = '0;
    port_sel_o = '0;
    for (int i = 0; i < SHARED_BANK_NUM; i++) begin
      if (pending_i[i] && (cnt < PORT_NUM)) begin
        sel_o[i] = 1'b1;
        port_sel_o[i*PORT_SEL_BITWIDTH +: PORT_SEL_BITWIDTH] = cnt[PORT_SEL_BITWIDTH-1:0];
        cnt++;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/memshare_grant_sched.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | memshare_grant_sched                                                       |
// | Serialises one batch of share requests onto PORT_NUM ports per cycle.      |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module memshare_grant_sched
  import memshare_pkg::*;
#(
  parameter int SHARED_BANK_NUM = 5,
  parameter int PORT_NUM        = 2,
  parameter int ROUND_BITWIDTH  = 3
) (
  input  logic                  sys_clk,
  input  logic                  rst,
  memshare_grant_sched_if.slave bus
);

  localparam int PORT_SEL_BITWIDTH = port_sel_width(PORT_NUM);
  localparam int PSW_TOTAL         = SHARED_BANK_NUM * PORT_SEL_BITWIDTH;

  state_e                      state_q, state_d;
  logic [SHARED_BANK_NUM-1:0]  pending_q, pending_d;
  logic [ROUND_BITWIDTH-1:0]   round_cnt_q, round_cnt_d;
  logic [SHARED_BANK_NUM-1:0]  grant_q, grant_d;
  logic                        grant_valid_q, grant_valid_d;
  logic [PSW_TOTAL-1:0]        port_sel_q, port_sel_d;
  logic [ROUND_BITWIDTH-1:0]   round_q, round_d;
  logic                        end_flag_q, end_flag_d;

  logic [SHARED_BANK_NUM-1:0]  sel;
  logic [PSW_TOTAL-1:0]        sel_port;
  logic                        last_grant;
  logic                        rqst_ready;
  logic                        accept;

  memshare_lowk_select #(
    .SHARED_BANK_NUM   (SHARED_BANK_NUM),
    .PORT_NUM          (PORT_NUM),
    .PORT_SEL_BITWIDTH (PORT_SEL_BITWIDTH)
  ) u_lowk_select (
    .pending_i  (pending_q),
    .sel_o      (sel),
    .port_sel_o (sel_port)
  );

  // Ready in the last serve cycle lets the next batch follow with no bubble.
  assign last_grant = ((pending_q & ~sel) == '0);
  assign rqst_ready = ~rst & ~bus.flush_i & ((state_q == ST_IDLE) | last_grant);
  assign accept     = bus.rqst_valid_i & rqst_ready;

  always_comb begin
    state_d       = state_q;
    pending_d     = pending_q;
    round_cnt_d   = round_cnt_q;
    grant_d       = '0;
    grant_valid_d = 1'b0;
    port_sel_d    = '0;
    round_d       = '0;
    end_flag_d    = 1'b0;
    if (bus.flush_i) begin
      state_d   = ST_IDLE;
      pending_d = '0;
    end else begin
      if (state_q == ST_SERVE) begin
        grant_d       = sel;
        grant_valid_d = |sel;
        port_sel_d    = sel_port;
        round_d       = round_cnt_q;
        pending_d     = pending_q & ~sel;
        round_cnt_d   = (round_cnt_q == {ROUND_BITWIDTH{1'b1}}) ? round_cnt_q
                        : round_cnt_q + ROUND_BITWIDTH'(1);
        if (last_grant) begin
          end_flag_d = 1'b1;
          state_d    = ST_IDLE;
        end
      end
      if (accept) begin
        pending_d   = bus.share_rqstFlag_i;
        round_cnt_d = '0;
        state_d     = ST_SERVE;
      end
    end
  end

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      pending_q     <= '0;
      round_cnt_q   <= '0;
      grant_q       <= '0;
      grant_valid_q <= 1'b0;
      port_sel_q    <= '0;
      round_q       <= '0;
      end_flag_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      pending_q     <= pending_d;
      round_cnt_q   <= round_cnt_d;
      grant_q       <= grant_d;
      grant_valid_q <= grant_valid_d;
      port_sel_q    <= port_sel_d;
      round_q       <= round_d;
      end_flag_q    <= end_flag_d;
    end
  end

  assign bus.rqst_ready_o  = rqst_ready;
  assign bus.grant_valid_o = grant_valid_q;
  assign bus.grant_o       = grant_q;
  assign bus.port_sel_o    = port_sel_q;
  assign bus.round_o       = round_q;
  assign bus.endFlag_o     = end_flag_q;

endmodule
`default_nettype wire

// File: tb/tb_memshare_grant_sched.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_memshare_grant_sched                                                    |
// | Directed plus random batches against a queue-of-grant-cycles model.        |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_memshare_grant_sched;

  localparam int N = 5;
  localparam int P = 2;
  localparam int R = 3;

  typedef struct packed {
    logic [N-1:0] grant;
    logic [N-1:0] psel;
    logic [R-1:0] round;
    logic         endf;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;
  exp_t q[$];

  always #5 clk = ~clk;

  memshare_grant_sched_if #(.SHARED_BANK_NUM(N), .PORT_NUM(P), .ROUND_BITWIDTH(R)) bus ();

  memshare_grant_sched #(.SHARED_BANK_NUM(N), .PORT_NUM(P), .ROUND_BITWIDTH(R)) dut (
    .sys_clk (clk),
    .rst     (rst),
    .bus     (bus.slave)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // A batch becomes ceil(n/P) cycles (min 1); the j-th set flag goes to cycle j/P, port j%P.
  task automatic push_batch(input logic [N-1:0] f);
    int   idx[$];
    int   n;
    int   cycles;
    int   j;
    exp_t e;
    for (int i = 0; i < N; i++) if (f[i]) idx.push_back(i);
    n      = idx.size();
    cycles = (n == 0) ? 1 : (n + P - 1) / P;
    for (int c = 0; c < cycles; c++) begin
      e = '0;
      for (int k = 0; k < P; k++) begin
        j = c * P + k;
        if (j < n) begin
          e.grant[idx[j]] = 1'b1;
          e.psel[idx[j]]  = (k == 1);
        end
      end
      e.round = R'((c > 7) ? 7 : c);
      e.endf  = (c == cycles - 1);
      q.push_back(e);
    end
  endtask

  task automatic check_outputs(input exp_t e);
    chk("grant", bus.grant_o, e.grant);
    chk("grant_valid", bus.grant_valid_o, |e.grant);
    chk("port_sel", bus.port_sel_o, e.psel);
    chk("round", bus.round_o, e.round);
    chk("endFlag", bus.endFlag_o, e.endf);
  endtask

  // Called at a falling edge: drive, check ready, advance the model, check outputs.
  task automatic cycle(input logic v, input logic [N-1:0] f, input logic fl);
    exp_t e;
    bit   rdy;
    bus.rqst_valid_i     = v;
    bus.share_rqstFlag_i = f;
    bus.flush_i          = fl;
    #1;
    rdy = !fl && (q.size() <= 1);
    chk("ready", bus.rqst_ready_o, rdy);
    if (fl) begin
      q.delete();
      e = '0;
    end else begin
      e = (q.size() > 0) ? q.pop_front() : '0;
      if (v && rdy) push_batch(f);
    end
    @(posedge clk);
    @(negedge clk);
    check_outputs(e);
  endtask

  initial begin
    rst                  = 1'b1;
    bus.rqst_valid_i     = 1'b0;
    bus.share_rqstFlag_i = '0;
    bus.flush_i          = 1'b0;
    #1;
    chk("reset_ready", bus.rqst_ready_o, 1'b0);
    check_outputs('0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // 10110: two grant cycles
    cycle(1'b1, 5'b10110, 1'b0);
    cycle(1'b0, 5'b00000, 1'b0);
    chk("t1_grant0", bus.grant_o, 5'b00110);
    chk("t1_psel0", bus.port_sel_o, 5'b00100);
    cycle(1'b0, 5'b00000, 1'b0);
    chk("t1_grant1", bus.grant_o, 5'b10000);
    chk("t1_end", bus.endFlag_o, 1'b1);
    cycle(1'b0, 5'b00000, 1'b0);

    // empty batch
    cycle(1'b1, 5'b00000, 1'b0);
    cycle(1'b0, 5'b00000, 1'b0);
    chk("t2_end", bus.endFlag_o, 1'b1);
    chk("t2_valid", bus.grant_valid_o, 1'b0);
    cycle(1'b0, 5'b00000, 1'b0);

    // back-to-back with valid held
    cycle(1'b1, 5'b11111, 1'b0);
    cycle(1'b1, 5'b00001, 1'b0);
    chk("t3_grant0", bus.grant_o, 5'b00011);
    cycle(1'b1, 5'b00001, 1'b0);
    chk("t3_grant1", bus.grant_o, 5'b01100);
    cycle(1'b1, 5'b00001, 1'b0);
    chk("t3_grant2", bus.grant_o, 5'b10000);
    cycle(1'b0, 5'b00000, 1'b0);
    chk("t3_b2b_grant", bus.grant_o, 5'b00001);
    chk("t3_b2b_round", bus.round_o, 3'd0);
    chk("t3_b2b_end", bus.endFlag_o, 1'b1);
    cycle(1'b0, 5'b00000, 1'b0);

    // flush after the first grant
    cycle(1'b1, 5'b11111, 1'b0);
    cycle(1'b0, 5'b00000, 1'b0);
    cycle(1'b0, 5'b00000, 1'b1);
    chk("t4_end", bus.endFlag_o, 1'b0);
    chk("t4_grant", bus.grant_o, 5'b00000);
    cycle(1'b0, 5'b00000, 1'b0);

    // request during a busy batch is dropped
    cycle(1'b1, 5'b11111, 1'b0);
    cycle(1'b1, 5'b01010, 1'b0);
    cycle(1'b0, 5'b00000, 1'b0);
    chk("t6_grant1", bus.grant_o, 5'b01100);
    cycle(1'b0, 5'b00000, 1'b0);
    cycle(1'b0, 5'b00000, 1'b0);
    chk("t6_idle", bus.grant_o, 5'b00000);

    // asynchronous reset mid-batch
    cycle(1'b1, 5'b11111, 1'b0);
    cycle(1'b0, 5'b00000, 1'b0);
    #2 rst = 1'b1;
    #1;
    chk("t5_ready", bus.rqst_ready_o, 1'b0);
    check_outputs('0);
    q.delete();
    @(negedge clk);
    rst = 1'b0;
    cycle(1'b1, 5'b00100, 1'b0);
    cycle(1'b0, 5'b00000, 1'b0);
    chk("t5_grant", bus.grant_o, 5'b00100);
    chk("t5_end", bus.endFlag_o, 1'b1);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      cycle(1'($urandom_range(0, 1)), N'($urandom), ($urandom_range(0, 15) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
